// File: rtl/jam_cost_server.sv
// jam_cost_server
// Responder side of the job-assignment cost-table interface. The host streams
// 64 cost entries (row-major, index = W*8+J) over a valid/ready channel; once
// the table is complete the engine reads Cost combinationally for its W/J
// address while the server counts service cycles, and the engine's result is
// captured on Valid.
//
// Handshake: a load beat transfers on a rising CLK edge where LD_VALID and
// LD_READY are both high. LD_READY does not depend on LD_VALID. LD_START on
// the same edge overrides the transfer, so that beat is dropped.
//
// Ports:
//   CLK, RST_N            clock (rising edge) and async active-low reset
//   LD_START              pulse: restart the table load from entry 0
//   LD_VALID/LD_DATA      load beat from host
//   LD_READY              server is in LOAD and accepts beats
//   W, J                  worker/job address from the engine
//   Cost                  table[W][J] while TABLE_READY, else 0
//   TABLE_READY           table complete (engine reset release)
//   MatchCount, MinCost   engine result, captured when Valid is high in SERVE
//   RES_MATCH, RES_MIN    captured result, held until the next capture
//   DONE                  result captured (sticky until LD_START/reset)
//   RD_CNT                SERVE cycles without Valid, saturating
//   DBG_STATE             current FSM state (0 LOAD, 1 SERVE, 2 DONE)
module jam_cost_server #(
  parameter int COST_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [COST_W-1:0] LD_DATA,
  output logic              LD_READY,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              TABLE_READY,
  input  logic [3:0]        MatchCount,
  input  logic [9:0]        MinCost,
  input  logic              Valid,
  output logic [3:0]        RES_MATCH,
  output logic [9:0]        RES_MIN,
  output logic              DONE,
  output logic [CNT_W-1:0]  RD_CNT,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_idx;
  logic [COST_W-1:0]  r_table [64];
  logic [3:0]         r_res_match;
  logic [9:0]         r_res_min;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic               w_accept;
  logic               w_capture;
  logic               w_count;

  // Next state and per-cycle strobes. LD_START wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_count     = 1'b0;
    if (LD_START) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (LD_VALID) begin
            w_accept = 1'b1;
            if (r_idx == 6'd63) w_state_nxt = S_SERVE;
          end
        end
        S_SERVE: begin
          if (Valid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            // Saturate rather than wrap.
            w_count = (r_rd_cnt != {CNT_W{1'b1}});
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load index wraps naturally from 63 to 0 on the final beat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx <= 6'd0;
    end else if (LD_START) begin
      r_idx <= 6'd0;
    end else if (w_accept) begin
      r_idx <= r_idx + 6'd1;
    end
  end

  // Table storage has no reset; entries are only meaningful once loaded.
  always_ff @(posedge CLK) begin
    if (w_accept) r_table[r_idx] <= LD_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_cnt <= '0;
    end else if (LD_START) begin
      r_rd_cnt <= '0;
    end else if (w_count) begin
      r_rd_cnt <= r_rd_cnt + CNT_W'(1);
    end
  end

  // Results survive LD_START; only a new capture or reset changes them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_res_match <= 4'd0;
      r_res_min   <= 10'd0;
    end else if (w_capture) begin
      r_res_match <= MatchCount;
      r_res_min   <= MinCost;
    end
  end

  assign LD_READY    = (r_state == S_LOAD);
  assign TABLE_READY = (r_state == S_SERVE) || (r_state == S_DONE);
  assign DONE        = (r_state == S_DONE);
  assign RES_MATCH   = r_res_match;
  assign RES_MIN     = r_res_min;
  assign RD_CNT      = r_rd_cnt;
  assign DBG_STATE   = r_state;

  // Purely combinational read: the engine moves W/J on the falling edge and
  // samples on the rising edge, so this path has half a cycle to settle.
  assign Cost = TABLE_READY ? r_table[{W, J}] : '0;

endmodule
